// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared definitions for the walking-sprite motion controller.
//   - action codes driven to the renderer's frame-index input
//   - controller state and requested-direction encodings
//   - helper that steps the three-image walk cycle
package sprite_motion_ctrl_pkg;

  localparam logic [2:0] ACT_IDLE  = 3'd0;
  localparam logic [2:0] ACT_WALK0 = 3'd1;
  localparam logic [2:0] ACT_WALK1 = 3'd2;
  localparam logic [2:0] ACT_WALK2 = 3'd3;
  localparam logic [2:0] ACT_SKID  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_SKID = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_L    = 2'd1,
    DIR_R    = 2'd2
  } dir_t;

  // Walk images cycle 1 -> 2 -> 3 -> 1.
  function automatic logic [2:0] next_walk_act(input logic [2:0] act);
    case (act)
      ACT_WALK0: next_walk_act = ACT_WALK1;
      ACT_WALK1: next_walk_act = ACT_WALK2;
      default:   next_walk_act = ACT_WALK0;
    endcase
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Signal bundle between the frame timing / button side and the motion
// controller.
//   frame_tick   frame strobe from the VGA timing generator (rising edge counts)
//   btn_left     raw button level, 1 = pressed
//   btn_right    raw button level, 1 = pressed
//   position     sprite x offset to the renderer
//   action       sprite frame index to the renderer
//   orientation  1 = facing right (unmirrored), 0 = facing left (mirrored)
// master: drives strobe and buttons; slave: the controller.
interface sprite_motion_ctrl_if;

  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic [8:0] position;
  logic [2:0] action;
  logic       orientation;

  modport master (
    output frame_tick,
    output btn_left,
    output btn_right,
    input  position,
    input  action,
    input  orientation
  );

  modport slave (
    input  frame_tick,
    input  btn_left,
    input  btn_right,
    output position,
    output action,
    output orientation
  );

endinterface

// File: rtl/sprite_motion_ctrl_btn_sync.sv
// Two-flop synchronizer for one raw asynchronous button level.
//   clk      system/pixel clock
//   reset_n  asynchronous active-low reset (clears both flops)
//   async_i  raw button level
//   sync_o   button level synchronized to clk
module sprite_motion_ctrl_btn_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame motion controller for the walking sprite. Converts left/right
// button levels into position, walk-cycle frame index and facing direction,
// advancing once per rising edge of frame_tick.
//   clk      system/pixel clock
//   reset_n  asynchronous active-low reset
//   bus      slave side of sprite_motion_ctrl_if (strobe and buttons in,
//            position/action/orientation out, all outputs registered)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | standing still, action 0
// ST_WALK | moving STEP per frame, walk images cycle every ANIM_DIV frames
// ST_SKID | reversal in progress, skid image held SKID_FRAMES frames
module sprite_motion_ctrl #(
  parameter int MIN_POS     = 0,
  parameter int MAX_POS     = 479,
  parameter int START_POS   = 64,
  parameter int STEP        = 2,
  parameter int ANIM_DIV    = 6,
  parameter int SKID_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sprite_motion_ctrl_if.slave  bus
);

  import sprite_motion_ctrl_pkg::*;

  localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int SKID_W = (SKID_FRAMES > 1) ? $clog2(SKID_FRAMES) : 1;
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
  localparam logic [SKID_W-1:0] SKID_LAST = SKID_W'(SKID_FRAMES - 1);

  logic sync_l;
  logic sync_r;

  sprite_motion_ctrl_btn_sync u_sync_l (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (bus.btn_left),
    .sync_o  (sync_l)
  );

  sprite_motion_ctrl_btn_sync u_sync_r (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (bus.btn_right),
    .sync_o  (sync_r)
  );

  state_t              state_q;
  logic [8:0]          pos_q;
  logic [2:0]          act_q;
  logic                ori_q;
  logic [ANIM_W-1:0]   anim_cnt_q;
  logic [SKID_W-1:0]   skid_cnt_q;
  logic                frame_tick_q;

  // A strobe held high for many cycles still advances the frame only once.
  logic tick;
  assign tick = bus.frame_tick & ~frame_tick_q;

  dir_t dir_req;
  logic dir_right;

  always_comb begin
    dir_req = DIR_NONE;
    case ({sync_l, sync_r})
      2'b01:   dir_req = DIR_R;
      2'b10:   dir_req = DIR_L;
      default: dir_req = DIR_NONE;
    endcase
  end

  assign dir_right = (dir_req == DIR_R);

  // Saturating move; 10-bit intermediates keep pos+STEP from wrapping.
  logic [9:0] right_sum;
  logic [9:0] left_diff;
  logic [8:0] pos_right;
  logic [8:0] pos_left;
  logic [8:0] pos_step;

  always_comb begin
    right_sum = {1'b0, pos_q} + 10'(STEP);
    left_diff = {1'b0, pos_q} - 10'(STEP);
    pos_right = (right_sum > 10'(MAX_POS)) ? 9'(MAX_POS) : right_sum[8:0];
    pos_left  = ({1'b0, pos_q} < 10'(MIN_POS + STEP)) ? 9'(MIN_POS) : left_diff[8:0];
    pos_step  = dir_right ? pos_right : pos_left;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pos_q        <= 9'(START_POS);
      act_q        <= ACT_IDLE;
      ori_q        <= 1'b1;
      anim_cnt_q   <= '0;
      skid_cnt_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= bus.frame_tick;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (dir_req != DIR_NONE) begin
              state_q    <= ST_WALK;
              ori_q      <= dir_right;
              act_q      <= ACT_WALK0;
              anim_cnt_q <= '0;
              pos_q      <= pos_step;
            end
          end

          ST_WALK: begin
            if (dir_req == DIR_NONE) begin
              state_q    <= ST_IDLE;
              act_q      <= ACT_IDLE;
              anim_cnt_q <= '0;
            end else if (dir_right == ori_q) begin
              pos_q <= pos_step;
              if (anim_cnt_q == ANIM_LAST) begin
                anim_cnt_q <= '0;
                act_q      <= next_walk_act(act_q);
              end else begin
                anim_cnt_q <= anim_cnt_q + ANIM_W'(1);
              end
            end else begin
              state_q    <= ST_SKID;
              ori_q      <= dir_right;
              act_q      <= ACT_SKID;
              skid_cnt_q <= '0;
            end
          end

          ST_SKID: begin
            // The skid runs to completion; buttons only matter on the exit tick.
            if (skid_cnt_q != SKID_LAST) begin
              skid_cnt_q <= skid_cnt_q + SKID_W'(1);
            end else if (dir_req == DIR_NONE) begin
              state_q    <= ST_IDLE;
              act_q      <= ACT_IDLE;
              anim_cnt_q <= '0;
            end else begin
              state_q    <= ST_WALK;
              ori_q      <= dir_right;
              act_q      <= ACT_WALK0;
              anim_cnt_q <= '0;
              pos_q      <= pos_step;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            act_q   <= ACT_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.position    = pos_q;
  assign bus.action      = act_q;
  assign bus.orientation = ori_q;

endmodule
